// File: rtl/memxfer_pkg.sv
// memxfer_pkg: shared definitions for the memxfer DMA block.
//   - FSM state encodings
//   - MMIO register offsets within the 16-byte window
//   - CTRL / STATUS bit positions
//   - min16 helper used for chunk sizing
package memxfer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_READ  = 2'b01,
      ST_WRITE = 2'b10
   } state_t;

   localparam logic [3:0] OFF_CTRL   = 4'd0;
   localparam logic [3:0] OFF_STATUS = 4'd1;
   localparam logic [3:0] OFF_RD_LO  = 4'd2;
   localparam logic [3:0] OFF_RD_HI  = 4'd3;
   localparam logic [3:0] OFF_WR_LO  = 4'd4;
   localparam logic [3:0] OFF_WR_HI  = 4'd5;
   localparam logic [3:0] OFF_LEN_LO = 4'd6;
   localparam logic [3:0] OFF_LEN_HI = 4'd7;
   localparam logic [3:0] OFF_FILL   = 4'd8;

   localparam int CTRL_START   = 0;
   localparam int CTRL_FILL    = 1;
   localparam int CTRL_ABORT   = 2;
   localparam int STAT_DONE    = 2;
   localparam int STAT_ABORTED = 3;

   function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/memxfer_if.sv
// memxfer_if: bundles the CPU MMIO bus and the XRAM master bus of the DMA.
//   slave  modport: the DMA view (responds on the CPU bus, issues XRAM requests)
//   master modport: the system view (drives CPU requests, answers XRAM requests)
// CPU bus : stb, wr, addr[15:0], data_in[7:0] -> data_out[7:0], ack, in_addr_range
// XRAM bus: xram_addr[15:0], xram_data_out[7:0], xram_stb, xram_wr <- xram_data_in[7:0], xram_ack
interface memxfer_if;
   logic        stb;
   logic        wr;
   logic [15:0] addr;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic        ack;
   logic        in_addr_range;
   logic [15:0] xram_addr;
   logic [7:0]  xram_data_out;
   logic        xram_stb;
   logic        xram_wr;
   logic [7:0]  xram_data_in;
   logic        xram_ack;

   modport slave (
      input  stb, wr, addr, data_in, xram_data_in, xram_ack,
      output data_out, ack, in_addr_range, xram_addr, xram_data_out, xram_stb, xram_wr
   );

   modport master (
      output stb, wr, addr, data_in, xram_data_in, xram_ack,
      input  data_out, ack, in_addr_range, xram_addr, xram_data_out, xram_stb, xram_wr
   );
endinterface

// File: rtl/memxfer_reg2byte.sv
// reg2byte: one 16-bit little-endian register written a byte at a time.
//   clk, rst : clock, synchronous active-high reset (clears to 0)
//   we_lo/hi : write enable for bits [7:0] / [15:8]
//   din      : write byte
//   q        : register value
module reg2byte (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_lo,
   input  logic        we_hi,
   input  logic [7:0]  din,
   output logic [15:0] q
);
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else begin
         if (we_lo) q[7:0]  <= din;
         if (we_hi) q[15:8] <= din;
      end
   end
endmodule

// File: rtl/memxfer_dma.sv
// memxfer_dma: MMIO-programmed XRAM-to-XRAM byte copier with a staging buffer.
// Copies LEN bytes from RD_ADDR to WR_ADDR in chunks of up to BUF_DEPTH bytes:
// each chunk is read into the buffer (READ) then written out (WRITE).
// Optional macro MEMXFER_FILL_EN adds fill mode (CTRL b1): write FILL LEN times.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : CPU MMIO bus + XRAM master bus
//   memxfer_state     : FSM state
//   memxfer_remaining : bytes still to write
//   memxfer_step      : state changes on the next edge
module memxfer_dma
   import memxfer_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'hfe50,
   parameter int          BUF_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   memxfer_if.slave    bus,
   output logic [1:0]  memxfer_state,
   output logic [15:0] memxfer_remaining,
   output logic        memxfer_step
);
   localparam int          IW      = $clog2(BUF_DEPTH);
   localparam logic [15:0] DEPTH16 = 16'(BUF_DEPTH);
   localparam logic [16:0] LIMIT   = {1'b0, BASE_ADDR} + 17'd16;

   state_t        state, state_nx;
   logic [IW-1:0] idx;
   logic [15:0]   copied, remaining, chunk;
   logic          done, aborted, fill_mode, fill_req;
   logic [7:0]    fill;
   logic [15:0]   rd_addr, wr_addr, len;
   logic [7:0]    buf_mem [BUF_DEPTH];

   logic       sel, wen, idle, cfg_we, ctrl_we, start, abort, last;
   logic [3:0] off;

   // ---- CPU bus decode ----
   assign bus.in_addr_range = (bus.addr >= BASE_ADDR) && ({1'b0, bus.addr} < LIMIT);
   assign sel     = bus.stb && bus.in_addr_range;
   assign bus.ack = sel;
   assign off     = bus.addr[3:0] - BASE_ADDR[3:0];
   assign wen     = sel && bus.wr;
   assign idle    = (state == ST_IDLE);
   assign cfg_we  = wen && idle;
   assign ctrl_we = wen && (off == OFF_CTRL);
   assign abort   = ctrl_we && bus.data_in[CTRL_ABORT];
   assign start   = ctrl_we && idle && bus.data_in[CTRL_START] && !bus.data_in[CTRL_ABORT];

   reg2byte u_rd  (.clk(clk), .rst(rst), .we_lo(cfg_we && off == OFF_RD_LO),
                   .we_hi(cfg_we && off == OFF_RD_HI), .din(bus.data_in), .q(rd_addr));
   reg2byte u_wr  (.clk(clk), .rst(rst), .we_lo(cfg_we && off == OFF_WR_LO),
                   .we_hi(cfg_we && off == OFF_WR_HI), .din(bus.data_in), .q(wr_addr));
   reg2byte u_len (.clk(clk), .rst(rst), .we_lo(cfg_we && off == OFF_LEN_LO),
                   .we_hi(cfg_we && off == OFF_LEN_HI), .din(bus.data_in), .q(len));

`ifdef MEMXFER_FILL_EN
   assign fill_req = bus.data_in[CTRL_FILL];

   always_ff @(posedge clk) begin
      if (rst)                                fill <= '0;
      else if (cfg_we && off == OFF_FILL)     fill <= bus.data_in;
   end

   // Mode is latched at start so it holds for the whole transfer.
   always_ff @(posedge clk) begin
      if (rst)        fill_mode <= 1'b0;
      else if (start) fill_mode <= fill_req;
   end
`else
   assign fill_req  = 1'b0;
   assign fill      = '0;
   assign fill_mode = 1'b0;
`endif

   // ---- register readback ----
   always_comb begin
      bus.data_out = '0;
      if (sel) begin
         case (off)
            OFF_STATUS: bus.data_out = {4'b0, aborted, done, state};
            OFF_RD_LO:  bus.data_out = rd_addr[7:0];
            OFF_RD_HI:  bus.data_out = rd_addr[15:8];
            OFF_WR_LO:  bus.data_out = wr_addr[7:0];
            OFF_WR_HI:  bus.data_out = wr_addr[15:8];
            OFF_LEN_LO: bus.data_out = len[7:0];
            OFF_LEN_HI: bus.data_out = len[15:8];
            OFF_FILL:   bus.data_out = fill;
            default:    bus.data_out = '0;
         endcase
      end
   end

   // chunk is latched per chunk; remaining shrinks during WRITE so it can't be used live.
   assign last = (16'(idx) == chunk - 16'd1);

   // ---- FSM: state register ----
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // ---- FSM: next state ----
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:
            if (start && len != 16'd0) state_nx = fill_req ? ST_WRITE : ST_READ;
         ST_READ:
            if (bus.xram_ack && last) state_nx = ST_WRITE;
         ST_WRITE:
            if (bus.xram_ack && last)
               state_nx = (remaining == 16'd1) ? ST_IDLE : (fill_mode ? ST_WRITE : ST_READ);
         default:
            state_nx = ST_IDLE;
      endcase
      if (abort) state_nx = ST_IDLE;
   end

   // ---- FSM: outputs ----
   always_comb begin
      bus.xram_stb      = 1'b0;
      bus.xram_wr       = 1'b0;
      bus.xram_addr     = '0;
      bus.xram_data_out = '0;
      case (state)
         ST_READ: begin
            bus.xram_stb  = 1'b1;
            bus.xram_addr = rd_addr + copied + 16'(idx);
         end
         ST_WRITE: begin
            bus.xram_stb      = 1'b1;
            bus.xram_wr       = 1'b1;
            bus.xram_addr     = wr_addr + copied + 16'(idx);
            bus.xram_data_out = fill_mode ? fill : buf_mem[idx];
         end
         default: ;
      endcase
   end

   // ---- datapath ----
   always_ff @(posedge clk) begin
      if (rst) begin
         idx       <= '0;
         copied    <= '0;
         remaining <= '0;
         chunk     <= '0;
         done      <= 1'b0;
         aborted   <= 1'b0;
      end else if (abort) begin
         idx     <= '0;
         done    <= 1'b0;
         aborted <= 1'b1;
      end else begin
         case (state)
            ST_IDLE:
               if (start) begin
                  done      <= (len == 16'd0);
                  aborted   <= 1'b0;
                  remaining <= len;
                  copied    <= '0;
                  idx       <= '0;
                  chunk     <= min16(len, DEPTH16);
               end
            ST_READ:
               if (bus.xram_ack) idx <= last ? '0 : idx + IW'(1);
            ST_WRITE:
               if (bus.xram_ack) begin
                  remaining <= remaining - 16'd1;
                  if (last) begin
                     idx    <= '0;
                     copied <= copied + chunk;
                     chunk  <= min16(remaining - 16'd1, DEPTH16);
                     if (remaining == 16'd1) done <= 1'b1;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
            default: idx <= '0;
         endcase
      end
   end

   // Staging buffer: no reset, every entry is rewritten before it is read.
   always_ff @(posedge clk) begin
      if (state == ST_READ && bus.xram_ack) buf_mem[idx] <= bus.xram_data_in;
   end

   assign memxfer_state     = state;
   assign memxfer_remaining = remaining;
   assign memxfer_step      = (state_nx != state);

endmodule

// File: tb/tb_memxfer_dma.sv
module tb_memxfer_dma;
   import memxfer_pkg::*;

   localparam logic [15:0] BASE = 16'hfe50;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  st;
   logic [15:0] rem;
   logic        step;

   always #5 clk = ~clk;

   memxfer_if bus ();

   memxfer_dma #(.BASE_ADDR(BASE), .BUF_DEPTH(16)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .memxfer_state(st), .memxfer_remaining(rem), .memxfer_step(step)
   );

   // ---- XRAM model ----
   typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;

   logic [7:0] mem [65536];
   bit         ack_en = 1'b1;
   int         stall_pct = 0;
   int         wlimit = 1 << 30;
   int         rcount = 0, wcount = 0, stbcount = 0, cur_burst = 0;
   wr_t        obs_q[$], exp_q[$];
   int         burst_q[$];
   int         total = 0, bad = 0;

   assign bus.xram_data_in = mem[bus.xram_addr];
   assign bus.xram_ack     = bus.xram_stb && ack_en && !(bus.xram_wr && wcount >= wlimit);

   always @(negedge clk) ack_en = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);

   always @(posedge clk) begin
      if (bus.xram_stb) stbcount <= stbcount + 1;
      if (st != 2'b01 && cur_burst > 0) begin
         burst_q.push_back(cur_burst);
         cur_burst <= 0;
      end else if (bus.xram_stb && bus.xram_ack && !bus.xram_wr) begin
         cur_burst <= cur_burst + 1;
      end
      if (bus.xram_stb && bus.xram_ack) begin
         if (bus.xram_wr) begin
            mem[bus.xram_addr] = bus.xram_data_out;
            obs_q.push_back({bus.xram_addr, bus.xram_data_out});
            wcount <= wcount + 1;
         end else begin
            rcount <= rcount + 1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---- CPU bus helpers ----
   task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.stb = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.data_in = d;
      @(negedge clk);
      bus.stb = 1'b0; bus.wr = 1'b0;
   endtask

   task automatic cpu_rd(input logic [15:0] a, output logic [7:0] d, output logic k, output logic r);
      @(negedge clk);
      bus.stb = 1'b1; bus.wr = 1'b0; bus.addr = a;
      #1;
      d = bus.data_out; k = bus.ack; r = bus.in_addr_range;
      bus.stb = 1'b0;
   endtask

   task automatic setup(input logic [15:0] ra, input logic [15:0] wa, input logic [15:0] n);
      cpu_wr(BASE + 16'(OFF_RD_LO),  ra[7:0]);
      cpu_wr(BASE + 16'(OFF_RD_HI),  ra[15:8]);
      cpu_wr(BASE + 16'(OFF_WR_LO),  wa[7:0]);
      cpu_wr(BASE + 16'(OFF_WR_HI),  wa[15:8]);
      cpu_wr(BASE + 16'(OFF_LEN_LO), n[7:0]);
      cpu_wr(BASE + 16'(OFF_LEN_HI), n[15:8]);
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (st == 2'b00) begin ok = 1'b1; break; end
      end
   endtask

   // Queue expected writes for a plain copy of n bytes.
   task automatic push_copy(input logic [15:0] ra, input logic [15:0] wa, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({wa + 16'(i), mem[ra + 16'(i)]});
   endtask

   // ---- tests ----
   task automatic test_reset();
      logic [7:0] d; logic k, r;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cpu_wr(BASE + 16'(OFF_RD_LO), 8'h12);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      total++; if (st !== 2'b00)  begin bad++; $display("FAIL reset_state got=%0d want=0", st); end
      total++; if (rem !== 16'd0) begin bad++; $display("FAIL reset_remaining got=%0d want=0", rem); end
      total++; if (bus.xram_stb !== 1'b0 || bus.xram_wr !== 1'b0)
         begin bad++; $display("FAIL reset_xram stb=%b wr=%b want 0/0", bus.xram_stb, bus.xram_wr); end
      cpu_rd(BASE + 16'(OFF_STATUS), d, k, r);
      total++; if (d !== 8'h00 || k !== 1'b1) begin bad++; $display("FAIL reset_status got=%h ack=%b want 00/1", d, k); end
      cpu_rd(BASE + 16'(OFF_RD_LO), d, k, r);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_rd_lo got=%h want=00", d); end
      cpu_rd(BASE + 16'd15, d, k, r);
      total++; if (r !== 1'b1 || k !== 1'b1) begin bad++; $display("FAIL range_top got r=%b k=%b want 1/1", r, k); end
      cpu_rd(BASE + 16'd16, d, k, r);
      total++; if (r !== 1'b0 || k !== 1'b0 || d !== 8'h00)
         begin bad++; $display("FAIL range_above got r=%b k=%b d=%h want 0/0/00", r, k, d); end
      cpu_rd(BASE - 16'd1, d, k, r);
      total++; if (r !== 1'b0 || k !== 1'b0) begin bad++; $display("FAIL range_below got r=%b k=%b want 0/0", r, k); end
   endtask

   task automatic test_copy5();
      logic [7:0] d; logic k, r; bit ok; int r0, w0;
      for (int i = 0; i < 5; i++) begin mem[16'h0100 + 16'(i)] = 8'($urandom); mem[16'h0200 + 16'(i)] = 8'h00; end
      obs_q.delete(); exp_q.delete();
      push_copy(16'h0100, 16'h0200, 5);
      setup(16'h0100, 16'h0200, 16'd5);
      r0 = rcount; w0 = wcount;
      cpu_wr(BASE + 16'(OFF_CTRL), 8'h01);
      wait_idle(200, ok);
      total++; if (!ok) begin bad++; $display("FAIL copy5_timeout state=%0d want 0", st); end
      total++; if (rcount - r0 != 5 || wcount - w0 != 5)
         begin bad++; $display("FAIL copy5_counts reads=%0d writes=%0d want 5/5", rcount - r0, wcount - w0); end
      total++; if (obs_q.size() != exp_q.size())
         begin bad++; $display("FAIL copy5_nwrites got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         wr_t o, e; o = obs_q.pop_front(); e = exp_q.pop_front();
         total++; if (o !== e) begin bad++; $display("FAIL copy5_write got=%h:%h want=%h:%h", o.a, o.d, e.a, e.d); end
      end
      cpu_rd(BASE + 16'(OFF_STATUS), d, k, r);
      total++; if (d !== 8'h04) begin bad++; $display("FAIL copy5_status got=%h want=04", d); end
   endtask

   task automatic test_chunks();
      logic [7:0] d; logic k, r; bit ok; int r0, w0;
      for (int i = 0; i < 40; i++) mem[16'h1000 + 16'(i)] = 8'($urandom);
      obs_q.delete(); exp_q.delete(); burst_q.delete();
      push_copy(16'h1000, 16'h2000, 40);
      setup(16'h1000, 16'h2000, 16'd40);
      r0 = rcount; w0 = wcount;
      stall_pct = 30;
      cpu_wr(BASE + 16'(OFF_CTRL), 8'h01);
      wait_idle(2000, ok);
      stall_pct = 0;
      @(negedge clk);
      total++; if (!ok) begin bad++; $display("FAIL chunks_timeout state=%0d want 0", st); end
      total++; if (rcount - r0 != 40 || wcount - w0 != 40)
         begin bad++; $display("FAIL chunks_counts reads=%0d writes=%0d want 40/40", rcount - r0, wcount - w0); end
      total++; if (burst_q.size() != 3)
         begin bad++; $display("FAIL chunks_nbursts got=%0d want=3", burst_q.size()); end
      else begin
         total++; if (burst_q[0] != 16 || burst_q[1] != 16 || burst_q[2] != 8)
            begin bad++; $display("FAIL chunks_sizes got=%0d,%0d,%0d want=16,16,8", burst_q[0], burst_q[1], burst_q[2]); end
      end
      total++; if (obs_q.size() != exp_q.size())
         begin bad++; $display("FAIL chunks_nwrites got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         wr_t o, e; o = obs_q.pop_front(); e = exp_q.pop_front();
         total++; if (o !== e) begin bad++; $display("FAIL chunks_write got=%h:%h want=%h:%h", o.a, o.d, e.a, e.d); end
      end
      total++; if (rem !== 16'd0) begin bad++; $display("FAIL chunks_remaining got=%0d want=0", rem); end
      cpu_rd(BASE + 16'(OFF_STATUS), d, k, r);
      total++; if (d !== 8'h04) begin bad++; $display("FAIL chunks_status got=%h want=04", d); end
   endtask

   task automatic test_len0();
      logic [7:0] d; logic k, r; int s0;
      cpu_wr(BASE + 16'(OFF_CTRL), 8'h04);
      cpu_rd(BASE + 16'(OFF_STATUS), d, k, r);
      total++; if (d !== 8'h08) begin bad++; $display("FAIL idle_abort_status got=%h want=08", d); end
      setup(16'h3000, 16'h3100, 16'd0);
      s0 = stbcount;
      cpu_wr(BASE + 16'(OFF_CTRL), 8'h01);
      cpu_rd(BASE + 16'(OFF_STATUS), d, k, r);
      total++; if (d !== 8'h04) begin bad++; $display("FAIL len0_status got=%h want=04", d); end
      repeat (5) @(negedge clk);
      total++; if (stbcount != s0 || st !== 2'b00)
         begin bad++; $display("FAIL len0_no_stb stb_cycles=%0d state=%0d want 0/0", stbcount - s0, st); end
   endtask

   task automatic test_wrap();
      bit ok;
      for (int i = 0; i < 4; i++) mem[16'h0300 + 16'(i)] = 8'($urandom);
      obs_q.delete(); exp_q.delete();
      // destination crosses 0xffff -> 0x0000
      exp_q.push_back({16'hfffe, mem[16'h0300]});
      exp_q.push_back({16'hffff, mem[16'h0301]});
      exp_q.push_back({16'h0000, mem[16'h0302]});
      exp_q.push_back({16'h0001, mem[16'h0303]});
      setup(16'h0300, 16'hfffe, 16'd4);
      cpu_wr(BASE + 16'(OFF_CTRL), 8'h01);
      wait_idle(200, ok);
      total++; if (!ok) begin bad++; $display("FAIL wrap_timeout state=%0d want 0", st); end
      total++; if (obs_q.size() != 4) begin bad++; $display("FAIL wrap_nwrites got=%0d want=4", obs_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         wr_t o, e; o = obs_q.pop_front(); e = exp_q.pop_front();
         total++; if (o !== e) begin bad++; $display("FAIL wrap_write got=%h:%h want=%h:%h", o.a, o.d, e.a, e.d); end
      end
   endtask

   task automatic test_abort();
      logic [7:0] d; logic k, r; bit ok; int w0;
      for (int i = 0; i < 20; i++) begin
         mem[16'h0400 + 16'(i)] = 8'(8'h40 + i);
         mem[16'h0500 + 16'(i)] = 8'h00;
      end
      obs_q.delete(); exp_q.delete();
      push_copy(16'h0400, 16'h0500, 3);   // only the first three writes may land
      setup(16'h0400, 16'h0500, 16'd20);
      w0 = wcount;
      wlimit = w0 + 3;                     // withhold ack from the 4th write on
      cpu_wr(BASE + 16'(OFF_CTRL), 8'h01);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (wcount - w0 >= 3) begin ok = 1'b1; break; end
      end
      total++; if (!ok) begin bad++; $display("FAIL abort_wait writes=%0d want=3", wcount - w0); end
      cpu_wr(BASE + 16'(OFF_LEN_LO), 8'h07);
      cpu_rd(BASE + 16'(OFF_LEN_LO), d, k, r);
      total++; if (d !== 8'h14) begin bad++; $display("FAIL busy_len_write got=%h want=14", d); end
      total++; if (st !== 2'b10) begin bad++; $display("FAIL abort_pre_state got=%0d want=2", st); end
      cpu_wr(BASE + 16'(OFF_CTRL), 8'h04);
      total++; if (st !== 2'b00) begin bad++; $display("FAIL abort_state got=%0d want=0", st); end
      wlimit = 1 << 30;
      repeat (3) @(negedge clk);
      cpu_rd(BASE + 16'(OFF_STATUS), d, k, r);
      total++; if (d !== 8'h08) begin bad++; $display("FAIL abort_status got=%h want=08", d); end
      total++; if (wcount - w0 != 3 || obs_q.size() != 3)
         begin bad++; $display("FAIL abort_nwrites got=%0d want=3", wcount - w0); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         wr_t o, e; o = obs_q.pop_front(); e = exp_q.pop_front();
         total++; if (o !== e) begin bad++; $display("FAIL abort_write got=%h:%h want=%h:%h", o.a, o.d, e.a, e.d); end
      end
      total++; if (mem[16'h0503] !== 8'h00) begin bad++; $display("FAIL abort_untouched got=%h want=00", mem[16'h0503]); end
   endtask

   task automatic test_fill();
      logic [7:0] d; logic k, r; bit ok; int r0;
      mem[16'h0600] = 8'h11; mem[16'h0601] = 8'h22; mem[16'h0602] = 8'h33;
      obs_q.delete(); exp_q.delete();
`ifdef MEMXFER_FILL_EN
      for (int i = 0; i < 3; i++) exp_q.push_back({16'h0700 + 16'(i), 8'hA5});
`else
      push_copy(16'h0600, 16'h0700, 3);
`endif
      cpu_wr(BASE + 16'(OFF_FILL), 8'hA5);
      setup(16'h0600, 16'h0700, 16'd3);
      r0 = rcount;
      cpu_wr(BASE + 16'(OFF_CTRL), 8'h03);
      wait_idle(200, ok);
      @(negedge clk);
      total++; if (!ok) begin bad++; $display("FAIL fill_timeout state=%0d want 0", st); end
      cpu_rd(BASE + 16'(OFF_FILL), d, k, r);
`ifdef MEMXFER_FILL_EN
      total++; if (d !== 8'hA5) begin bad++; $display("FAIL fill_reg got=%h want=a5", d); end
      total++; if (rcount != r0) begin bad++; $display("FAIL fill_reads got=%0d want=0", rcount - r0); end
`else
      total++; if (d !== 8'h00) begin bad++; $display("FAIL fill_reg got=%h want=00", d); end
      total++; if (rcount - r0 != 3) begin bad++; $display("FAIL fill_reads got=%0d want=3", rcount - r0); end
`endif
      total++; if (obs_q.size() != 3) begin bad++; $display("FAIL fill_nwrites got=%0d want=3", obs_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         wr_t o, e; o = obs_q.pop_front(); e = exp_q.pop_front();
         total++; if (o !== e) begin bad++; $display("FAIL fill_write got=%h:%h want=%h:%h", o.a, o.d, e.a, e.d); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d; logic k, r; bit ok;
      for (int i = 0; i < 6; i++) begin mem[16'h0a00 + 16'(i)] = 8'($urandom); mem[16'h0c00 + 16'(i)] = 8'($urandom); end
      obs_q.delete(); exp_q.delete();
      push_copy(16'h0a00, 16'h0b00, 6);
      push_copy(16'h0c00, 16'h0d00, 6);
      setup(16'h0a00, 16'h0b00, 16'd6);
      stall_pct = 50;
      cpu_wr(BASE + 16'(OFF_CTRL), 8'h01);
      cpu_wr(BASE + 16'(OFF_RD_LO), 8'h55);   // busy: must be ignored
      cpu_wr(BASE + 16'(OFF_CTRL), 8'h01);    // busy: restart must be ignored
      cpu_rd(BASE + 16'(OFF_RD_LO), d, k, r);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL busy_rd_write got=%h want=00", d); end
      wait_idle(500, ok);
      total++; if (!ok) begin bad++; $display("FAIL b2b_first_timeout state=%0d want 0", st); end
      setup(16'h0c00, 16'h0d00, 16'd6);
      cpu_wr(BASE + 16'(OFF_CTRL), 8'h01);
      wait_idle(500, ok);
      stall_pct = 0;
      @(negedge clk);
      total++; if (!ok) begin bad++; $display("FAIL b2b_second_timeout state=%0d want 0", st); end
      total++; if (obs_q.size() != 12) begin bad++; $display("FAIL b2b_nwrites got=%0d want=12", obs_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         wr_t o, e; o = obs_q.pop_front(); e = exp_q.pop_front();
         total++; if (o !== e) begin bad++; $display("FAIL b2b_write got=%h:%h want=%h:%h", o.a, o.d, e.a, e.d); end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d; logic k, r;
      setup(16'h0800, 16'h0900, 16'd30);
      cpu_wr(BASE + 16'(OFF_CTRL), 8'h01);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (st !== 2'b00 || rem !== 16'd0 || bus.xram_stb !== 1'b0)
         begin bad++; $display("FAIL midreset_state st=%0d rem=%0d stb=%b want 0/0/0", st, rem, bus.xram_stb); end
      cpu_rd(BASE + 16'(OFF_STATUS), d, k, r);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL midreset_status got=%h want=00", d); end
      cpu_rd(BASE + 16'(OFF_LEN_LO), d, k, r);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL midreset_len got=%h want=00", d); end
   endtask

   initial begin
      bus.stb = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.data_in = '0;
      rst = 1'b1;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      test_reset();
      test_copy5();
      test_chunks();
      test_len0();
      test_wrap();
      test_abort();
      test_fill();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
